// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/XOR/AND and an iterative one-bit-per-clock SRA.
// Results and flags are registered and presented to writeback as a one-cycle out_valid pulse.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] fast_res;
  logic             fast_carry;
  logic [WIDTH-1:0] acc_shifted;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign sum         = {1'b0, a} + {1'b0, b};
  assign acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
  assign shamt       = b[SHW-1:0];

  always_comb begin
    fast_res   = '0;
    fast_carry = 1'b0;
    case (alu_op)
      OP_ADD: begin
        fast_res   = sum[WIDTH-1:0];
        fast_carry = sum[WIDTH];
      end
      OP_XOR:  fast_res = a ^ b;
      OP_AND:  fast_res = a & b;
      default: fast_res = a;
    endcase
  end

  // Flush aborts any in-flight work but leaves the last completed result/flags untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
      carry  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && in_valid) begin
            if (alu_op == OP_SRA) begin
              if (shamt == CNT_ZERO) begin
                result <= a;
                zero   <= (a == '0);
                carry  <= 1'b0;
                state  <= ST_DONE;
              end else begin
                acc   <= a;
                cnt   <= shamt;
                state <= ST_SHIFT;
              end
            end else begin
              result <= fast_res;
              zero   <= (fast_res == '0);
              carry  <= fast_carry;
              state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            acc <= acc_shifted;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              result <= acc_shifted;
              zero   <= (acc_shifted == '0);
              carry  <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected responses,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        carry;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sb[$];
  time  vt[$];
  int   n_compared;
  int   n_mismatched;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .result   (result),
    .zero     (zero),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a request at a negedge, wait for in_ready, and return just after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input bit push, input logic [31:0] er, input logic ez, input logic ec);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = op;
    a        = av;
    b        = bv;
    w = 0;
    while (!in_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
    if (push) sb.push_back('{r: er, z: ez, c: ec});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ez, input logic ec, input int lat);
    int busy;
    int seen;
    applyStimulus(op, av, bv, 1'b1, er, ez, ec);
    busy = 0;
    seen = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (out_valid && seen < 0) seen = i;
      if (in_ready) break;
      busy++;
    end
    checkOutput({name, "_latency"}, seen, lat);
    checkOutput({name, "_busy"}, busy, lat);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      vt.push_back($time);
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_out_valid: got result 0x%08h, expected no pulse at %0t", result, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.r);
        checkOutput("zero", {31'd0, zero}, {31'd0, e.z});
        checkOutput("carry", {31'd0, carry}, {31'd0, e.c});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    alu_op   = 2'b00;
    a        = '0;
    b        = '0;
    flush    = 1'b0;

    #2 rst = 1'b1;
    #5;
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_carry", {31'd0, carry}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
    run_op("add_zero", 2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op("xor", 2'b01, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1);
    run_op("and", 2'b10, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'hA5A5_0000, 1'b0, 1'b0, 1);
    run_op("and_zero", 2'b10, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op("sra4", 2'b11, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 5);
    run_op("sra0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
    run_op("sra31_neg", 2'b11, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    run_op("sra31_pos", 2'b11, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 1'b1, 1'b0, 32);

    // in_valid held through SHIFT: only one accept may happen.
    applyStimulus(2'b11, 32'h0000_0100, 32'd3, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back ADDs with in_valid held continuously.
    vt.delete();
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      int w;
      logic [31:0] av, bv, er;
      logic ez, ec;
      case (k)
        0: begin av = 32'd1;         bv = 32'd2;         er = 32'd3;         ez = 1'b0; ec = 1'b0; end
        1: begin av = 32'h7FFF_FFFF; bv = 32'd1;         er = 32'h8000_0000; ez = 1'b0; ec = 1'b0; end
        2: begin av = 32'h8000_0000; bv = 32'h8000_0000; er = 32'd0;         ez = 1'b1; ec = 1'b1; end
        default: begin av = 32'd10;  bv = 32'd20;        er = 32'd30;        ez = 1'b0; ec = 1'b0; end
      endcase
      w = 0;
      while (!in_ready && w < 8) begin
        @(negedge clk);
        w++;
      end
      a = av;
      b = bv;
      sb.push_back('{r: er, z: ez, c: ec});
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_count", vt.size(), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (i < vt.size()) checkOutput("b2b_spacing", 32'(vt[i] - vt[i-1]), 32'd20);
    end

    // Flush in IDLE beats a simultaneous request.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_op   = 2'b00;
    a        = 32'd7;
    b        = 32'd8;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // Flush in the third SHIFT cycle of SRA by 10; prior XOR result must survive.
    run_op("xor_prior", 2'b01, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0, 1);
    applyStimulus(2'b11, 32'h8000_0000, 32'd10, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_shift_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_shift_result", result, 32'h5A5A_A5A5);
    checkOutput("flush_shift_zero", {31'd0, zero}, 32'd0);
    repeat (12) @(negedge clk);

    // Asynchronous reset between edges in the middle of an SRA.
    applyStimulus(2'b11, 32'h8000_0000, 32'd10, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_result", result, 32'h0);
    checkOutput("async_rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after_rst", 2'b00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
